// File: rtl/dm_sbus_arbiter_pkg.sv
// Shared constants and helpers for the debug-module system-bus arbiter slice.
// Requester vectors stay flat, so this package only carries sizing defaults.
package dm_sbus_arbiter_pkg;

  localparam int unsigned SbusNrMasters      = 2;
  localparam int unsigned SbusBusWidth       = 32;
  localparam int unsigned SbusMaxOutstanding = 2;

  // Index width that never collapses to zero bits for single-entry structures.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_sbus_arbiter_if.sv
// Downstream system-bus port (req/gnt/r_valid protocol) shared by all requesters.
// The arbiter drives it through the master modport; the bus fabric sees the slave side.
interface dm_sbus_arbiter_if
  import dm_sbus_arbiter_pkg::*;
#(
  parameter int unsigned BusWidth = SbusBusWidth
);

  logic                  req;
  logic [BusWidth-1:0]   add;
  logic                  we;
  logic [BusWidth-1:0]   wdata;
  logic [BusWidth/8-1:0] be;
  logic                  gnt;
  logic                  r_valid;
  logic [BusWidth-1:0]   r_rdata;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_valid, r_rdata
  );

endinterface

// File: rtl/dm_sbus_owner_fifo.sv
// In-order FIFO recording which requester owns each granted-but-unanswered bus access.
// The head is read combinationally so a response can be routed in the cycle it arrives.
module dm_sbus_owner_fifo
  import dm_sbus_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 1,
  parameter int unsigned Depth     = SbusMaxOutstanding,
  localparam int unsigned PtrW     = idx_width(Depth),
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntW-1:0]      count_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still pops; the freed slot is only visible through full_o next cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/dm_sbus_arbiter.sv
// Round-robin arbiter sharing the debug module's single system-bus master port.
// A waiting request is locked until granted; responses are routed by an in-order owner FIFO.
module dm_sbus_arbiter
  import dm_sbus_arbiter_pkg::*;
#(
  parameter int unsigned NrMasters      = SbusNrMasters,
  parameter int unsigned BusWidth       = SbusBusWidth,
  parameter int unsigned MaxOutstanding = SbusMaxOutstanding
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrMasters-1:0]            req_i,
  input  logic [NrMasters-1:0]            we_i,
  input  logic [NrMasters*BusWidth-1:0]   addr_i,
  input  logic [NrMasters*BusWidth-1:0]   wdata_i,
  input  logic [NrMasters*BusWidth/8-1:0] be_i,
  output logic [NrMasters-1:0]            gnt_o,
  output logic [NrMasters-1:0]            r_valid_o,
  output logic [BusWidth-1:0]             r_rdata_o,
  output logic                            spurious_o,
  dm_sbus_arbiter_if.master               sbus
);

  localparam int unsigned IdxW = idx_width(NrMasters);
  localparam int unsigned BeW  = BusWidth / 8;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [BusWidth-1:0] addr_arr  [NrMasters];
  logic [BusWidth-1:0] wdata_arr [NrMasters];
  logic [BeW-1:0]      be_arr    [NrMasters];

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_valid_q, lock_valid_d;
  logic [IdxW-1:0] sel, cand;
  logic            found;
  logic            master_req, handshake;
  logic            fifo_full, fifo_empty;
  logic [IdxW-1:0] head;
  logic [CntW-1:0] fifo_count;

  for (genvar gi = 0; gi < NrMasters; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr_i[gi*BusWidth +: BusWidth];
    assign wdata_arr[gi] = wdata_i[gi*BusWidth +: BusWidth];
    assign be_arr[gi]    = be_i[gi*BeW +: BeW];
  end

  // A held lock pins the selection; otherwise search upward from rr_ptr with wrap.
  always_comb begin
    sel   = lock_idx_q;
    found = lock_valid_q;
    cand  = '0;
    for (int k = 0; k < int'(NrMasters); k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(NrMasters));
      if (!found && req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign master_req = (|req_i) & ~fifo_full;
  assign handshake  = master_req & sbus.gnt;

  assign sbus.req   = master_req;
  assign sbus.add   = master_req ? addr_arr[sel]  : '0;
  assign sbus.we    = master_req ? we_i[sel]      : 1'b0;
  assign sbus.wdata = master_req ? wdata_arr[sel] : '0;
  assign sbus.be    = master_req ? be_arr[sel]    : '0;

  assign r_rdata_o  = sbus.r_rdata;
  assign spurious_o = sbus.r_valid & fifo_empty;

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (handshake) begin
      gnt_o[sel] = 1'b1;
    end
    if (sbus.r_valid && !fifo_empty) begin
      r_valid_o[head] = 1'b1;
    end
  end

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    rr_ptr_d     = rr_ptr_q;
    if (handshake) begin
      lock_valid_d = 1'b0;
      rr_ptr_d     = (sel == IdxW'(NrMasters - 1)) ? '0 : sel + IdxW'(1);
    end else if (master_req) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_idx_q   <= '0;
      lock_valid_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_idx_q   <= lock_idx_d;
      lock_valid_q <= lock_valid_d;
    end
  end

  dm_sbus_owner_fifo #(
    .DataWidth (IdxW),
    .Depth     (MaxOutstanding)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (sbus.r_valid),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Requester protocol checks: the arbiter relies on these but never corrects them.
  for (genvar gi = 0; gi < NrMasters; gi++) begin : g_req_stable
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i[gi] && !gnt_o[gi]) |=>
        (req_i[gi] && $stable(we_i[gi])
         && $stable(addr_i[gi*BusWidth +: BusWidth])
         && $stable(wdata_i[gi*BusWidth +: BusWidth])
         && $stable(be_i[gi*BeW +: BeW])));
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o) && (fifo_count <= CntW'(MaxOutstanding)));

endmodule

// File: tb/tb_dm_sbus_arbiter.sv
// Directed, table-driven bench for dm_sbus_arbiter (2 requesters, 32-bit, 2 outstanding).
// Each row is one clock of stimulus with hand-computed expected outputs; state carries across rows.
module tb_dm_sbus_arbiter;
  import dm_sbus_arbiter_pkg::*;

  localparam int NM = 2;
  localparam int BW = 32;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'hA0A0_A0A0;
  localparam logic [31:0] W1 = 32'hB1B1_B1B1;
  localparam logic [3:0]  B0 = 4'hF;
  localparam logic [3:0]  B1 = 4'h3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]      req;
  logic [NM-1:0]      we;
  logic [NM*BW-1:0]   addr;
  logic [NM*BW-1:0]   wdata;
  logic [NM*BW/8-1:0] be;
  logic [NM-1:0]      gnt;
  logic [NM-1:0]      rv;
  logic [BW-1:0]      rdata;
  logic               spur;

  dm_sbus_arbiter_if #(.BusWidth(BW)) sbus ();

  dm_sbus_arbiter #(
    .NrMasters      (NM),
    .BusWidth       (BW),
    .MaxOutstanding (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .be_i       (be),
    .gnt_o      (gnt),
    .r_valid_o  (rv),
    .r_rdata_o  (rdata),
    .spurious_o (spur),
    .sbus       (sbus)
  );

  typedef struct {
    logic [1:0]  req;
    logic        mg;
    logic        mrv;
    logic [31:0] rd;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    int          exp_src;   // requester whose payload is on the bus, -1 = bus idle
    logic        exp_spur;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic [1:0] r, input logic g, input logic v,
                              input logic [31:0] d, input logic [1:0] eg,
                              input logic [1:0] ev, input int es, input logic sp);
    vec_t t;
    t.req = r; t.mg = g; t.mrv = v; t.rd = d;
    t.exp_gnt = eg; t.exp_rv = ev; t.exp_src = es; t.exp_spur = sp;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    logic [31:0] e_add, e_wd;
    logic [3:0]  e_be;
    logic        e_we, e_req;
    @(negedge clk);
    req           = v.req;
    sbus.gnt      = v.mg;
    sbus.r_valid  = v.mrv;
    sbus.r_rdata  = v.rd;
    #2;
    case (v.exp_src)
      0:       begin e_req = 1'b1; e_add = A0; e_we = 1'b0; e_wd = W0; e_be = B0; end
      1:       begin e_req = 1'b1; e_add = A1; e_we = 1'b1; e_wd = W1; e_be = B1; end
      default: begin e_req = 1'b0; e_add = '0; e_we = 1'b0; e_wd = '0; e_be = '0; end
    endcase
    $display("[TB] %s req=%b mgnt=%b mrv=%b | gnt=%b r_valid=%b mreq=%b add=%h spurious=%b",
             tag, v.req, v.mg, v.mrv, gnt, rv, sbus.req, sbus.add, spur);
    check({tag, " gnt_o"},          64'(gnt),        64'(v.exp_gnt));
    check({tag, " r_valid_o"},      64'(rv),         64'(v.exp_rv));
    check({tag, " master_req_o"},   64'(sbus.req),   64'(e_req));
    check({tag, " master_add_o"},   64'(sbus.add),   64'(e_add));
    check({tag, " master_we_o"},    64'(sbus.we),    64'(e_we));
    check({tag, " master_wdata_o"}, 64'(sbus.wdata), 64'(e_wd));
    check({tag, " master_be_o"},    64'(sbus.be),    64'(e_be));
    check({tag, " spurious_o"},     64'(spur),       64'(v.exp_spur));
    check({tag, " r_rdata_o"},      64'(rdata),      64'(v.rd));
  endtask

  initial begin
    req          = '0;
    we           = 2'b10;
    addr         = {A1, A0};
    wdata        = {W1, W0};
    be           = {B1, B0};
    sbus.gnt     = 1'b0;
    sbus.r_valid = 1'b0;
    sbus.r_rdata = '0;

    //                req    mg    mrv   rdata          gnt    rv    src  spur
    // reset state, then single requester with grant after two waiting cycles
    vecs[0]  = mk(2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, -1, 1'b0);
    vecs[1]  = mk(2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00,  0, 1'b0);
    vecs[2]  = mk(2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00,  0, 1'b0);
    vecs[3]  = mk(2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00,  0, 1'b0);
    vecs[4]  = mk(2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  2'b01 & 2'b00, 2'b01, -1, 1'b0);
    // round-robin under contention, responses overlapping new grants
    vecs[5]  = mk(2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00,  1, 1'b0);
    vecs[6]  = mk(2'b11, 1'b1, 1'b1, 32'h11111111,  2'b01, 2'b10,  0, 1'b0);
    vecs[7]  = mk(2'b11, 1'b1, 1'b1, 32'h22222222,  2'b10, 2'b01,  1, 1'b0);
    vecs[8]  = mk(2'b01, 1'b1, 1'b1, 32'h33333333,  2'b01, 2'b10,  0, 1'b0);
    vecs[9]  = mk(2'b10, 1'b1, 1'b1, 32'h44444444,  2'b10, 2'b01,  1, 1'b0);
    vecs[10] = mk(2'b00, 1'b0, 1'b1, 32'h55555555,  2'b00, 2'b10, -1, 1'b0);
    // lock: requester 1 waits, requester 0 rises but must not steal the bus
    vecs[11] = mk(2'b10, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00,  1, 1'b0);
    vecs[12] = mk(2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00,  1, 1'b0);
    vecs[13] = mk(2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00,  1, 1'b0);
    vecs[14] = mk(2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00,  1, 1'b0);
    vecs[15] = mk(2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00,  0, 1'b0);
    // full FIFO: request masked, a pop frees the slot only from the next cycle
    vecs[16] = mk(2'b01, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, -1, 1'b0);
    vecs[17] = mk(2'b01, 1'b1, 1'b1, 32'h66666666,  2'b00, 2'b10, -1, 1'b0);
    vecs[18] = mk(2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00,  0, 1'b0);
    vecs[19] = mk(2'b00, 1'b0, 1'b1, 32'h77777777,  2'b00, 2'b01, -1, 1'b0);
    vecs[20] = mk(2'b00, 1'b0, 1'b1, 32'h88888888,  2'b00, 2'b01, -1, 1'b0);
    // spurious response on an empty FIFO
    vecs[21] = mk(2'b00, 1'b0, 1'b1, 32'h99999999,  2'b00, 2'b00, -1, 1'b1);
    vecs[22] = mk(2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, -1, 1'b0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset with one transaction outstanding; its late response must be spurious.
    step("rst_a", mk(2'b10, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00, 1, 1'b0));
    @(negedge clk);
    req          = '0;
    sbus.gnt     = 1'b0;
    rst_n        = 1'b0;
    #2;
    $display("[TB] rst_b reset asserted | gnt=%b r_valid=%b mreq=%b spurious=%b",
             gnt, rv, sbus.req, spur);
    check("rst_b gnt_o", 64'(gnt), 64'(2'b00));
    check("rst_b master_req_o", 64'(sbus.req), 64'(1'b0));
    check("rst_b spurious_o", 64'(spur), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_c", mk(2'b00, 1'b0, 1'b1, 32'hABCD0123, 2'b00, 2'b00, -1, 1'b1));
    // rr_ptr and lock were cleared: with both requesting, requester 0 wins first
    step("rst_d", mk(2'b11, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 0, 1'b0));
    step("rst_e", mk(2'b11, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00, 0, 1'b0));
    step("rst_f", mk(2'b10, 1'b1, 1'b1, 32'h0BADF00D, 2'b10, 2'b01, 1, 1'b0));
    step("rst_g", mk(2'b00, 1'b0, 1'b1, 32'h0C0FFEE0, 2'b00, 2'b10, -1, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
